// File: rtl/panel_pkg.sv
// Shared types and constants for the panel scroll sequencer.
// Character geometry, shift-mode codes and FSM state encoding.
package panel_pkg;

    localparam int CHAR_W  = 7;
    localparam int DIGITS  = 4;
    localparam int PANEL_W = CHAR_W * DIGITS;
    localparam int BIT_W   = $clog2(CHAR_W);

    localparam logic [1:0] SH_HOLD = 2'b00;
    localparam logic [1:0] SH_MSB  = 2'b01;
    localparam logic [1:0] SH_LSB  = 2'b10;
    localparam logic [1:0] SH_LOAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT,
        ST_FETCH,
        ST_SHIFT
    } state_t;

    // Bit b of a character in serial order: LSB-first or MSB-first.
    function automatic logic pick_bit(
        input logic [CHAR_W-1:0] w,
        input logic [BIT_W-1:0]  b,
        input logic              msb_first
    );
        logic [BIT_W-1:0] i;
        i = msb_first ? BIT_W'(CHAR_W - 1) - b : b;
        return w[i];
    endfunction

endpackage

// File: rtl/panel_scroll_ctrl_if.sv
// Control, message-write and register-command bundle of the
// panel scroll sequencer; master = host side, slave = sequencer.
interface panel_scroll_ctrl_if
    import panel_pkg::*;
#(
    parameter int MSG_LEN = 8
);
    localparam int AW = $clog2(MSG_LEN);

    logic              start;
    logic              stop;
    logic              dir;
    logic              msg_we;
    logic [AW-1:0]     msg_waddr;
    logic [CHAR_W-1:0] msg_wdata;
    logic              load;
    logic [1:0]        s;
    logic              m_sig;
    logic [PANEL_W-1:0] d;
    logic              busy;
    logic              done;
    logic [AW-1:0]     char_idx;

    modport master (
        output start, stop, dir, msg_we, msg_waddr, msg_wdata,
        input  load, s, m_sig, d, busy, done, char_idx
    );

    modport slave (
        input  start, stop, dir, msg_we, msg_waddr, msg_wdata,
        output load, s, m_sig, d, busy, done, char_idx
    );

endinterface

// File: rtl/panel_tick_div.sv
// Loadable down-counter with zero flag; times the pause
// between characters.
module panel_tick_div #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic         en,
    input  logic [W-1:0] ld_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Reload has priority; counting stops at zero.
    always_ff @(posedge clk) begin
        if (clr)
            cnt_q <= '0;
        else if (ld)
            cnt_q <= ld_val;
        else if (en && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/panel_scroll_ctrl.sv
// Scroll sequencer driving the 28-bit panel shift register.
// Define SCROLL_LOOP_EN to repeat the message until stop or clr.
module panel_scroll_ctrl
    import panel_pkg::*;
#(
    parameter int MSG_LEN  = 8,
    parameter int TICK_DIV = 50000
) (
    input logic clk,
    input logic clr,
    panel_scroll_ctrl_if.slave bus
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LD = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] LAST = AW'(MSG_LEN - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAR_W - 1);

    state_t state_q, state_n;

    logic [CHAR_W-1:0] msg_q [MSG_LEN];
    logic [CHAR_W-1:0] buf_q, buf_n;
    logic [BIT_W-1:0]  bit_q, bit_n;
    logic [AW-1:0]     idx_q, idx_n;
    logic              dir_q, dir_n;
    logic              load_q, load_n;
    logic [1:0]        s_q, s_n;
    logic              m_q, m_n;
    logic              busy_q;
    logic              done_q, done_n;
    logic              tick_ld, tick_en, tick_zero;
    logic [1:0]        sh_code;

    assign sh_code = dir_q ? SH_LSB : SH_MSB;

    panel_tick_div #(.W(TW)) u_tick (
        .clk    (clk),
        .clr    (clr),
        .ld     (tick_ld),
        .en     (tick_en),
        .ld_val (TICK_LD),
        .zero   (tick_zero)
    );

    // Message store; writes accepted in every state.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < MSG_LEN; i++)
                msg_q[i] <= '0;
        end else if (bus.msg_we) begin
            msg_q[bus.msg_waddr] <= bus.msg_wdata;
        end
    end

    // Next state plus the values every output takes in that state.
    always_comb begin
        state_n = state_q;
        buf_n   = buf_q;
        bit_n   = bit_q;
        idx_n   = idx_q;
        dir_n   = dir_q;
        load_n  = 1'b0;
        s_n     = SH_HOLD;
        m_n     = 1'b0;
        done_n  = 1'b0;
        tick_ld = 1'b0;
        tick_en = 1'b0;
        if (bus.stop) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        dir_n   = bus.dir;
                        idx_n   = '0;
                        load_n  = 1'b1;
                        state_n = ST_INIT;
                    end
                end
                ST_INIT: begin
                    tick_ld = 1'b1;
                    state_n = ST_WAIT;
                end
                ST_WAIT: begin
                    if (tick_zero)
                        state_n = ST_FETCH;
                    else
                        tick_en = 1'b1;
                end
                ST_FETCH: begin
                    buf_n   = msg_q[idx_q];
                    bit_n   = '0;
                    s_n     = sh_code;
                    m_n     = pick_bit(msg_q[idx_q], '0, dir_q);
                    state_n = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_q == BIT_LAST) begin
                        if (idx_q == LAST) begin
                            done_n = 1'b1;
`ifdef SCROLL_LOOP_EN
                            idx_n   = '0;
                            tick_ld = 1'b1;
                            state_n = ST_WAIT;
`else
                            state_n = ST_IDLE;
`endif
                        end else begin
                            idx_n   = idx_q + 1'b1;
                            tick_ld = 1'b1;
                            state_n = ST_WAIT;
                        end
                    end else begin
                        bit_n = bit_q + 1'b1;
                        s_n   = sh_code;
                        m_n   = pick_bit(buf_q, bit_q + 1'b1, dir_q);
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            load_q  <= 1'b0;
            s_q     <= SH_HOLD;
            m_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            buf_q   <= buf_n;
            bit_q   <= bit_n;
            idx_q   <= idx_n;
            dir_q   <= dir_n;
            load_q  <= load_n;
            s_q     <= s_n;
            m_q     <= m_n;
            busy_q  <= (state_n != ST_IDLE);
            done_q  <= done_n;
        end
    end

    assign bus.load     = load_q;
    assign bus.s        = s_q;
    assign bus.m_sig    = m_q;
    assign bus.d        = '0;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.char_idx = idx_q;

endmodule

// File: tb/tb_panel_scroll_ctrl.sv
// Randomized bench for panel_scroll_ctrl against a phase-arithmetic
// reference and a model of the downstream 28-bit register.
module tb_panel_scroll_ctrl;
    import panel_pkg::*;

    localparam int ML = 2;
    localparam int TD = 4;
    localparam int CP = TD + 1 + CHAR_W;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    panel_scroll_ctrl_if #(.MSG_LEN(ML)) bus();

    panel_scroll_ctrl #(
        .MSG_LEN  (ML),
        .TICK_DIV (TD)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    bit           m_act;
    int           m_k;
    bit           m_dir;
    int           m_idx;
    bit           m_done;
    logic [6:0]   m_msg [ML];
    logic [6:0]   m_buf;
    logic [6:0]   fetched [$];
    logic [27:0]  panel;
    logic         p_load;
    logic [1:0]   p_s;
    logic         p_m;
    logic [27:0]  p_d;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Panel content expected from the characters shifted so far.
    function automatic logic [27:0] exp_panel();
        logic [27:0] p;
        p = '0;
        foreach (fetched[i]) begin
            if (m_dir)
                p = {p[20:0], fetched[i]};
            else
                p = {fetched[i], p[27:7]};
        end
        return p;
    endfunction

    task automatic model_edge();
        int kk, ph, ch;
        m_done = 1'b0;
        if (clr) begin
            m_act = 1'b0;
            m_idx = 0;
            foreach (m_msg[i]) m_msg[i] = '0;
        end else begin
            if (bus.stop) begin
                m_act = 1'b0;
            end else if (!m_act) begin
                if (bus.start) begin
                    m_act = 1'b1;
                    m_k   = 0;
                    m_dir = bus.dir;
                    m_idx = 0;
                    fetched.delete();
                end
            end else begin
                m_k++;
                kk = m_k - 1;
                ph = kk % CP;
                ch = kk / CP;
`ifdef SCROLL_LOOP_EN
                if (ph == 0 && ch > 0 && ch % ML == 0) m_done = 1'b1;
                m_idx = ch % ML;
`else
                if (ch == ML) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_idx = ch;
                end
`endif
                if (m_act && ph == TD + 1) begin
                    m_buf = m_msg[m_idx];
                    fetched.push_back(m_buf);
                end
            end
            if (bus.msg_we) m_msg[bus.msg_waddr] = bus.msg_wdata;
        end
    endtask

    task automatic step();
        logic       e_load, e_m;
        logic [1:0] e_s;
        int         ph, j;
        @(posedge clk);
        if (p_load)
            panel = p_d;
        else if (p_s == SH_MSB)
            panel = {p_m, panel[27:1]};
        else if (p_s == SH_LSB)
            panel = {panel[26:0], p_m};
        model_edge();
        #1;
        e_load = m_act && m_k == 0;
        e_s    = SH_HOLD;
        e_m    = 1'b0;
        if (m_act && m_k > 0) begin
            ph = (m_k - 1) % CP;
            if (ph > TD) begin
                j   = ph - TD - 1;
                e_s = m_dir ? SH_LSB : SH_MSB;
                e_m = m_dir ? m_buf[6 - j] : m_buf[j];
            end
        end
        chk("load", 32'(bus.load), 32'(e_load));
        chk("s", 32'(bus.s), 32'(e_s));
        chk("m_sig", 32'(bus.m_sig), 32'(e_m));
        chk("d", 32'(bus.d), 32'd0);
        chk("busy", 32'(bus.busy), 32'(m_act));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("char_idx", 32'(bus.char_idx), 32'(m_idx));
        if (m_done) chk("panel", 32'(panel), 32'(exp_panel()));
        p_load = bus.load;
        p_s    = bus.s;
        p_m    = bus.m_sig;
        p_d    = bus.d;
    endtask

    task automatic wr(int a, logic [6:0] v);
        bus.msg_we    = 1'b1;
        bus.msg_waddr = 1'(a);
        bus.msg_wdata = v;
        step();
        bus.msg_we = 1'b0;
    endtask

    task automatic run_full(bit dr);
        int cnt;
        bus.dir   = dr;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cnt = 0;
        while (!bus.done && cnt < 100) begin
            step();
            cnt++;
        end
        chk("init_to_done", 32'(cnt), 32'(2 * CP + 1));
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        step();
    endtask

    initial begin
        m_act = 1'b0; m_k = 0; m_dir = 1'b0; m_idx = 0;
        m_done = 1'b0; m_buf = '0; panel = '0;
        foreach (m_msg[i]) m_msg[i] = '0;
        p_load = 1'b0; p_s = '0; p_m = 1'b0; p_d = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.dir = 1'b0;
        bus.msg_we = 1'b0; bus.msg_waddr = '0; bus.msg_wdata = '0;
        clr = 1'b1;
        step();
        step();
        clr = 1'b0;
        repeat (20) step();

        wr(0, 7'h3F);
        wr(1, 7'h06);
        run_full(1'b0);
        run_full(1'b1);

        // stop in the third shift cycle of slot 0, then restart
        bus.dir = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (TD + 3) step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        repeat (3) step();
        run_full(1'b0);

        // rewrite slot 0 while it is being shifted
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (TD + 3) step();
        wr(0, 7'h7F);
        repeat (3 * CP) step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;

        // start with stop in idle; start while waiting
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (2) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (2 * CP) step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;

        repeat (60) begin
            repeat ($urandom_range(0, 3)) step();
            bus.dir   = 1'($urandom);
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            repeat ($urandom_range(0, 40)) begin
                bus.msg_we    = ($urandom_range(0, 9) == 0);
                bus.msg_waddr = 1'($urandom);
                bus.msg_wdata = 7'($urandom);
                bus.start     = ($urandom_range(0, 19) == 0);
                bus.dir       = 1'($urandom);
                bus.stop      = ($urandom_range(0, 39) == 0);
                clr           = ($urandom_range(0, 79) == 0);
                step();
            end
            bus.msg_we = 1'b0;
            bus.start  = 1'b0;
            clr        = 1'b0;
            bus.stop   = 1'b1;
            step();
            bus.stop = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
